sdp_bram_scheduler: RTL and testbench
=====================================

# sdp_bram_scheduler

Shares one RAMB18E1 configured in SDP mode (READ_WIDTH_A=36, WRITE_WIDTH_B=36, READ_FIRST) between NREQ write clients and NREQ read clients.

- Runs a zero-fill sweep after every reset.
- Arbitrates each port round-robin with valid/ready handshakes.
- Registers all BRAM controls.
- Returns read data tagged with the requester index.

It sits between fabric masters and a single LOC'd BRAM primitive.

## Interface
Parameters:
- ADDR_W, 9, BRAM address width (512 × 36 SDP)
- DATA_W, 36, data width including parity bits
- NREQ, 2, clients per port (2..4)
- DO_REG, 0, BRAM output register enable (0 or 1); must match the primitive's DOA_REG/DOB_REG

Ports (single clock domain; reset is synchronous and active-high):
- clk  in  1  sole clock; also drives BRAM CLKARDCLK/CLKBWRCLK
- rst  in  1  synchronous reset, active-high
- wr_valid  in  NREQ  write request per client
- wr_ready  out  NREQ  write grant; a transfer occurs when valid && ready
- wr_addr  in  NREQ*ADDR_W  write address, client i at slice i
- wr_data  in  NREQ*DATA_W  write data
- wr_be  in  NREQ*4  byte enables
- rd_valid  in  NREQ  read request per client
- rd_ready  out  NREQ  read grant
- rd_addr  in  NREQ*ADDR_W  read address
- rsp_valid  out  1  read data valid; no backpressure
- rsp_id  out  $clog2(NREQ)  client index of the response
- rsp_data  out  DATA_W  read data
- init_done  out  1  zero-fill complete
- ram_wren, ram_we[3:0], ram_waddr, ram_wdata  out  BRAM write side (port B)
- ram_rden, ram_raddr, ram_regce  out  BRAM read side (port A)
- ram_rdata  in  DATA_W  BRAM DO

## Operation
- FSM states: INIT → RUN.
  - rst forces INIT from any state.
  - INIT moves to RUN after the last fill write.
- **INIT**
  - A fill counter walks 0 .. 2^ADDR_W−1, issuing one write per cycle: ram_we=4'hF, ram_wdata=0.
  - All wr_ready and rd_ready are 0.
- **RUN, per-port round-robin**
  - Each port keeps a pointer to its last-granted client.
  - At most one client is granted per port per cycle: the first asserted valid searching from pointer+1 upward, with wrap.
  - The pointer updates only on a grant.
  - ready is combinational from valid, pointer and state.
  - A sole requester is granted every cycle.
- **Collision**
  - Condition: the read winner's address equals the write winner's address in the same cycle.
  - The write is granted; rd_ready stays 0 and the read pointer does not move.
  - The read retries next cycle, so it returns the newly written data (write-before-read ordering).
- **Read tracking**
  - A shift register of depth 2+DO_REG carries {valid, id} for each granted read.
  - rsp_data = ram_rdata (pass-through), qualified by the tail of the shift register.
- **Reset mid-operation**
  - The shift register is cleared, so in-flight reads never produce rsp_valid.
  - Round-robin pointers return to NREQ−1, so client 0 has first priority.
  - The fill restarts at address 0.

## Timing
- All outputs other than the ready signals are registered.
- Reset values (cycle after rst high): every output is 0, including ram_wren, ram_rden, rsp_valid, init_done, ram_regce and wr_ready/rd_ready.
- Fill: the first rst-low cycle is C0. ram_wren=1 with ram_waddr=k on cycle C(k+1), for k = 0..2^ADDR_W−1.
- init_done rises on cycle C(2^ADDR_W) and stays high until rst. Readies may assert on that same cycle.
- Write grant at cycle T: ram_wren/addr/data/we are driven on T+1 for exactly one cycle.
- Read grant at cycle T:
  - ram_rden/raddr are driven on T+1.
  - ram_regce is high on T+2 when DO_REG=1.
  - rsp_valid, with the matching rsp_id, is high on T+2+DO_REG for one cycle.
- Throughput is one write and one read per cycle. Responses return in grant order.
- Idle cycles: ram_wren=ram_rden=0, and ram_we=0.

## Structure
- A shared package holds:
  - the FSM state enum (ST_INIT, ST_RUN);
  - the latency constant RD_LAT = 2+DO_REG;
  - the byte-enable width constant BE_W = 4.
- One sub-module, `rr_arbiter`: parameter N; inputs clk, rst, req[N], en; outputs gnt[N] (one-hot), gnt_idx.
  - `en` allows the collision rule to suppress the read port's grant.
  - It is instantiated twice, once per port.

## Test plan
- **Reset/fill:** deassert rst.
  - Required: 512 consecutive ram_wren pulses with addresses 0..511 and data 0; init_done rises on C512.
  - Reading address 0x1F3 after init_done returns 36'h0.
- **Round-robin:** both wr_valid held high for 6 cycles.
  - Required: grants alternate 0,1,0,1,0,1.
  - With only client 1 valid, it is granted every cycle.
- **Read latency/tag:** client 1 reads address 5 (previously written with 36'h9_ABCD_1234) at T.
  - DO_REG=0: rsp_valid, rsp_id=1 and rsp_data=36'h9_ABCD_1234 at T+2.
  - DO_REG=1: the same response at T+3, with ram_regce high at T+2.
- **Collision:** write to address 0x40 with data 36'h1 and read of address 0x40 presented in the same cycle.
  - Required: wr_ready=1 and rd_ready=0 that cycle; the read is granted the next cycle and returns 36'h1.
- **Reset mid-flight:** assert rst one cycle after a read grant.
  - Required: no rsp_valid is ever produced for that read; the fill restarts at address 0.
  - After init_done, client 0 wins the first contended grant.

Source files
------------

// File: rtl/sdp_bram_scheduler_pkg.sv
// rtl/sdp_bram_scheduler_pkg.sv - shared state type and constants for the SDP BRAM scheduler
package sdp_bram_scheduler_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int BE_W        = 4;
  localparam int RD_LAT_BASE = 2;

  // Read-grant to rsp_valid latency: address register, BRAM read, optional DO register.
  function automatic int rd_lat(input int do_reg);
    return RD_LAT_BASE + do_reg;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter; pointer holds the last granted client
module rr_arbiter
  import sdp_bram_scheduler_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] r_ptr;
  logic          w_any;
  logic [IW-1:0] w_idx;
  int            w_sum;

  // gnt_idx is the candidate even when en is low, so the parent can inspect it.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    w_sum = 0;
    for (int k = 1; k <= N; k++) begin
      w_sum = int'(r_ptr) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      if (!w_any && req[w_sum[IW-1:0]]) begin
        w_any = 1'b1;
        w_idx = w_sum[IW-1:0];
      end
    end
  end

  assign gnt_idx = w_idx;
  assign gnt     = (en && w_any) ? (N'(1) << w_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= IW'(N - 1);
    end else if (en && w_any) begin
      r_ptr <= w_idx;
    end
  end

endmodule

// File: rtl/sdp_bram_scheduler.sv
// rtl/sdp_bram_scheduler.sv - shares one SDP BRAM between NREQ writers and NREQ readers
module sdp_bram_scheduler
  import sdp_bram_scheduler_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 36,
  parameter int NREQ   = 2,
  parameter int DO_REG = 0,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          wr_valid,
  output logic [NREQ-1:0]          wr_ready,
  input  logic [NREQ*ADDR_W-1:0]   wr_addr,
  input  logic [NREQ*DATA_W-1:0]   wr_data,
  input  logic [NREQ*BE_W-1:0]     wr_be,
  input  logic [NREQ-1:0]          rd_valid,
  output logic [NREQ-1:0]          rd_ready,
  input  logic [NREQ*ADDR_W-1:0]   rd_addr,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     init_done,
  output logic                     ram_wren,
  output logic [BE_W-1:0]          ram_we,
  output logic [ADDR_W-1:0]        ram_waddr,
  output logic [DATA_W-1:0]        ram_wdata,
  output logic                     ram_rden,
  output logic [ADDR_W-1:0]        ram_raddr,
  output logic                     ram_regce,
  input  logic [DATA_W-1:0]        ram_rdata
);

  localparam int RD_LAT = rd_lat(DO_REG);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_fill;
  logic                r_init_done;
  logic                r_ram_wren;
  logic [BE_W-1:0]     r_ram_we;
  logic [ADDR_W-1:0]   r_ram_waddr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic                r_ram_rden;
  logic [ADDR_W-1:0]   r_ram_raddr;
  logic [RD_LAT-1:0]   r_pv;
  logic [IDW-1:0]      r_pid [RD_LAT];

  logic                w_run;
  logic                w_col;
  logic [NREQ-1:0]     w_wr_gnt;
  logic [NREQ-1:0]     w_rd_gnt;
  logic [IDW-1:0]      w_wr_idx;
  logic [IDW-1:0]      w_rd_idx;
  logic                w_wr_fire;
  logic                w_rd_fire;
  logic [ADDR_W-1:0]   w_wr_sel_addr;
  logic [ADDR_W-1:0]   w_rd_sel_addr;
  logic [DATA_W-1:0]   w_wr_sel_data;
  logic [BE_W-1:0]     w_wr_sel_be;

  assign w_run         = (r_state == ST_RUN);
  assign w_wr_sel_addr = wr_addr[w_wr_idx*ADDR_W +: ADDR_W];
  assign w_wr_sel_data = wr_data[w_wr_idx*DATA_W +: DATA_W];
  assign w_wr_sel_be   = wr_be[w_wr_idx*BE_W +: BE_W];
  assign w_rd_sel_addr = rd_addr[w_rd_idx*ADDR_W +: ADDR_W];

  // A read that hits the winning write's address waits a cycle so it observes the new data.
  assign w_col = (|wr_valid) && (|rd_valid) && (w_rd_sel_addr == w_wr_sel_addr);

  rr_arbiter #(.N(NREQ)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_valid),
    .en      (w_run),
    .gnt     (w_wr_gnt),
    .gnt_idx (w_wr_idx)
  );

  rr_arbiter #(.N(NREQ)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_valid),
    .en      (w_run && !w_col),
    .gnt     (w_rd_gnt),
    .gnt_idx (w_rd_idx)
  );

  assign wr_ready  = w_wr_gnt;
  assign rd_ready  = w_rd_gnt;
  assign w_wr_fire = |w_wr_gnt;
  assign w_rd_fire = |w_rd_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_fill      <= '0;
      r_init_done <= 1'b0;
      r_ram_wren  <= 1'b0;
      r_ram_we    <= '0;
      r_ram_waddr <= '0;
      r_ram_wdata <= '0;
      r_ram_rden  <= 1'b0;
      r_ram_raddr <= '0;
      r_pv        <= '0;
      for (int i = 0; i < RD_LAT; i++) r_pid[i] <= '0;
    end else begin
      r_pv     <= {r_pv[RD_LAT-2:0], w_rd_fire};
      r_pid[0] <= w_rd_idx;
      for (int i = 1; i < RD_LAT; i++) r_pid[i] <= r_pid[i-1];
      case (r_state)
        ST_INIT: begin
          r_ram_wren  <= 1'b1;
          r_ram_we    <= '1;
          r_ram_waddr <= r_fill;
          r_ram_wdata <= '0;
          r_ram_rden  <= 1'b0;
          if (r_fill == '1) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end else begin
            r_fill <= r_fill + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          r_ram_wren <= w_wr_fire;
          r_ram_we   <= w_wr_fire ? w_wr_sel_be : '0;
          r_ram_rden <= w_rd_fire;
          if (w_wr_fire) begin
            r_ram_waddr <= w_wr_sel_addr;
            r_ram_wdata <= w_wr_sel_data;
          end
          if (w_rd_fire) r_ram_raddr <= w_rd_sel_addr;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign init_done = r_init_done;
  assign ram_wren  = r_ram_wren;
  assign ram_we    = r_ram_we;
  assign ram_waddr = r_ram_waddr;
  assign ram_wdata = r_ram_wdata;
  assign ram_rden  = r_ram_rden;
  assign ram_raddr = r_ram_raddr;
  assign ram_regce = (DO_REG != 0) && r_pv[1];
  assign rsp_valid = r_pv[RD_LAT-1];
  assign rsp_id    = r_pid[RD_LAT-1];
  assign rsp_data  = ram_rdata;

endmodule

// File: tb/tb_sdp_bram_scheduler.sv
// tb/tb_sdp_bram_scheduler.sv - randomized scoreboard bench for sdp_bram_scheduler
module tb_sdp_bram_scheduler;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 36;
  localparam int NREQ   = 2;
  localparam int DO_REG = 0;
  localparam int IDW    = $clog2(NREQ);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LAT    = 2 + DO_REG;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         wr_valid, wr_ready, rd_valid, rd_ready;
  logic [NREQ*ADDR_W-1:0]  wr_addr, rd_addr;
  logic [NREQ*DATA_W-1:0]  wr_data;
  logic [NREQ*4-1:0]       wr_be;
  logic                    rsp_valid, init_done, ram_wren, ram_rden, ram_regce;
  logic [IDW-1:0]          rsp_id;
  logic [DATA_W-1:0]       rsp_data, ram_wdata, ram_rdata;
  logic [3:0]              ram_we;
  logic [ADDR_W-1:0]       ram_waddr, ram_raddr;

  sdp_bram_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREQ(NREQ), .DO_REG(DO_REG)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .init_done(init_done),
    .ram_wren(ram_wren), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_rden(ram_rden), .ram_raddr(ram_raddr), .ram_regce(ram_regce), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // BRAM primitive model: READ_FIRST, 9-bit lanes per byte enable, optional DO register.
  logic [DATA_W-1:0] bram [DEPTH];
  logic [DATA_W-1:0] do_lat, do_reg;
  always @(posedge clk) begin
    if (ram_rden) do_lat <= bram[ram_raddr];
    if (ram_wren)
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) bram[ram_waddr][9*b +: 9] <= ram_wdata[9*b +: 9];
    if (ram_regce) do_reg <= do_lat;
  end
  assign ram_rdata = (DO_REG != 0) ? do_reg : do_lat;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory contents and the last client served on each port.
  typedef struct {
    int                cyc;
    int                id;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] mem [DEPTH];
  int                wr_last, rd_last;
  logic [NREQ-1:0]   got_wr, got_rd;

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    wr_last = NREQ - 1;
    rd_last = NREQ - 1;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    sb.delete();
  endtask

  logic prev_regce = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=1 expected=0 id=%0d (cycle %0d)", rsp_id, cyc);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_data", 64'(rsp_data), 64'(e.data));
        chk("rsp_latency", 64'(cyc - e.cyc), 64'(LAT));
        chk("regce_before_rsp", 64'(prev_regce), 64'(DO_REG != 0));
      end
    end
    prev_regce = ram_regce;
  end

  // Called just after a posedge; readies are compared at the following negedge.
  task automatic step(input logic [NREQ-1:0] wv, input logic [NREQ-1:0] rv,
                      input logic [NREQ*ADDR_W-1:0] wa, input logic [NREQ*DATA_W-1:0] wd,
                      input logic [NREQ*4-1:0] wbe, input logic [NREQ*ADDR_W-1:0] ra);
    int ew, er;
    logic [ADDR_W-1:0] a;
    exp_t e;
    wr_valid = wv; rd_valid = rv; wr_addr = wa; wr_data = wd; wr_be = wbe; rd_addr = ra;
    @(negedge clk);
    ew = pick(wv, wr_last);
    er = pick(rv, rd_last);
    if (ew >= 0 && er >= 0 && wa[ew*ADDR_W +: ADDR_W] == ra[er*ADDR_W +: ADDR_W]) er = -1;
    chk("wr_ready", 64'(wr_ready), (ew >= 0) ? (64'd1 << ew) : 64'd0);
    chk("rd_ready", 64'(rd_ready), (er >= 0) ? (64'd1 << er) : 64'd0);
    got_wr = wr_ready;
    got_rd = rd_ready;
    if (er >= 0) begin
      rd_last = er;
      e.cyc = cyc;
      e.id = er;
      e.data = mem[ra[er*ADDR_W +: ADDR_W]];
      sb.push_back(e);
    end
    if (ew >= 0) begin
      wr_last = ew;
      a = wa[ew*ADDR_W +: ADDR_W];
      for (int b = 0; b < 4; b++)
        if (wbe[ew*4 + b]) mem[a][9*b +: 9] = wd[ew*DATA_W + 9*b +: 9];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    wr_valid = '1; rd_valid = '1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'({wr_ready, rd_ready}), 64'd0);
    chk("rst_ram_en", 64'({ram_wren, ram_rden, ram_regce}), 64'd0);
    chk("rst_rsp_init", 64'({rsp_valid, init_done}), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_fill();
    int nbad = 0, rdy_bad = 0;
    rst = 1'b0;
    @(negedge clk);
    chk("fill_c0_idle", 64'(ram_wren), 64'd0);
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      if (!(ram_wren && ram_waddr == ADDR_W'(k) && ram_wdata == '0 && ram_we == 4'hF)) nbad++;
      if (k < DEPTH - 1) begin
        if (init_done) nbad++;
        if (wr_ready != '0 || rd_ready != '0) rdy_bad++;
      end
      if (k == DEPTH - 2) begin
        wr_valid = '0;
        rd_valid = '0;
      end
    end
    chk("init_done_c512", 64'(init_done), 64'd1);
    chk("fill_sequence_bad", 64'(nbad), 64'd0);
    chk("fill_ready_bad", 64'(rdy_bad), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NREQ*ADDR_W-1:0] wa, ra;
    logic [NREQ*DATA_W-1:0] wd;
    logic [NREQ*4-1:0]      wbe;
    int                     guard;

    for (int i = 0; i < DEPTH; i++) bram[i] = {$urandom, $urandom};
    rst = 1'b1;
    wr_valid = '0; rd_valid = '0; wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    @(posedge clk);
    #1;
    apply_reset();
    run_fill();

    // Contended writes alternate, then a sole requester wins every cycle.
    for (int i = 0; i < 6; i++) begin
      wa = {9'(20 + 2*i + 1), 9'(20 + 2*i)};
      wd = {36'(i + 100), 36'(i + 200)};
      step(2'b11, 2'b00, wa, wd, 8'hFF, '0);
      chk("rr_alternate", 64'(got_wr), (i % 2 == 0) ? 64'd1 : 64'd2);
    end
    for (int i = 0; i < 3; i++) begin
      step(2'b10, 2'b00, {9'(40 + i), 9'd0}, {36'(300 + i), 36'd0}, 8'hF0, '0);
      chk("rr_sole_client1", 64'(got_wr), 64'd2);
    end

    step(2'b00, 2'b01, '0, '0, '0, {9'd0, 9'h1F3});
    chk("read_1f3_grant", 64'(got_rd), 64'd1);

    step(2'b01, 2'b00, {9'd0, 9'd5}, {36'd0, 36'h9_ABCD_1234}, 8'h0F, '0);
    step(2'b00, 2'b10, '0, '0, '0, {9'd5, 9'd0});
    chk("read_c1_grant", 64'(got_rd), 64'd2);

    step(2'b01, 2'b01, {9'd0, 9'h40}, {36'd0, 36'h1}, 8'h0F, {9'd0, 9'h40});
    chk("collision_wr", 64'(got_wr), 64'd1);
    chk("collision_rd", 64'(got_rd), 64'd0);
    step(2'b00, 2'b01, '0, '0, '0, {9'd0, 9'h40});
    chk("collision_retry", 64'(got_rd), 64'd1);

    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NREQ; c++) begin
        wa[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 15));
        ra[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 15));
        wd[c*DATA_W +: DATA_W] = {$urandom, $urandom};
        wbe[c*4 +: 4]          = 4'($urandom);
      end
      step(NREQ'($urandom), NREQ'($urandom), wa, wd, wbe, ra);
    end
    repeat (LAT + 1) step('0, '0, '0, '0, '0, '0);

    // Reset one cycle after a read grant: that read must never respond.
    step(2'b00, 2'b01, '0, '0, '0, {9'd0, 9'd7});
    chk("midflight_grant", 64'(got_rd), 64'd1);
    apply_reset();
    run_fill();
    step(2'b11, 2'b11, {9'd61, 9'd60}, {36'd2, 36'd1}, 8'hFF, {9'd63, 9'd62});
    chk("post_reset_wr_c0", 64'(got_wr), 64'd1);
    chk("post_reset_rd_c0", 64'(got_rd), 64'd1);

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      step('0, '0, '0, '0, '0, '0);
      guard++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
